// File: rtl/uart_byte_tx.sv
// uart_byte_tx: byte-wide UART transmitter with RS-485 driver-enable control.
// Frame: optional DE lead bit, start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_byte_tx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DE_LEAD   = 1
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_state,
   output logic       tx_done,
   output logic       rs485_de,
   output logic       rs232_tx
);

   localparam int          BPS_PARAM = CLK_FREQ / BAUD_RATE;
   localparam logic [15:0] BPS_LAST  = 16'(BPS_PARAM - 1);
   localparam logic        PAR_EN    = (PARITY == 1) || (PARITY == 2);
   localparam logic        PAR_ODD   = (PARITY == 1);
   localparam logic        LEAD_EN   = (DE_LEAD == 1);
   localparam logic [2:0]  STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_PAR   = 3'd4;
   localparam logic [2:0] S_STOP  = 3'd5;
   localparam logic [2:0] S_END   = 3'd6;

   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  data_q, data_d;
   logic        par_q, par_d;
   logic        tx_q, tx_d;
   logic        de_q, de_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        accept;
   logic        bit_end;
   logic        par_calc;
   logic [2:0]  nxt_idx;

   assign accept   = tx_start && !busy_q;
   assign bit_end  = (cnt_q == BPS_LAST);
   assign par_calc = (^tx_data) ^ PAR_ODD;
   assign nxt_idx  = bit_q + 3'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      data_d  = data_q;
      par_d   = par_q;
      tx_d    = tx_q;
      de_d    = de_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (state_q != S_IDLE && state_q != S_END) begin
         cnt_d = bit_end ? '0 : cnt_q + 16'd1;
      end

      case (state_q)
         // END accepts like IDLE so back-to-back frames need no extra idle cycle
         S_IDLE, S_END: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            de_d    = 1'b0;
            if (accept) begin
               data_d  = tx_data;
               par_d   = par_calc;
               busy_d  = 1'b1;
               de_d    = 1'b1;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = LEAD_EN ? S_LEAD : S_START;
               tx_d    = LEAD_EN;
            end
         end
         S_LEAD: begin
            if (bit_end) begin
               state_d = S_START;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = data_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  bit_d = '0;
                  if (PAR_EN) begin
                     state_d = S_PAR;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = nxt_idx;
                  tx_d  = data_q[nxt_idx];
               end
            end
         end
         S_PAR: begin
            if (bit_end) begin
               state_d = S_STOP;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_q == STOP_LAST) begin
                  state_d = S_END;
                  bit_d   = '0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  tx_d    = 1'b1;
                  // a request already pending keeps the driver on through END
                  de_d    = tx_start;
               end else begin
                  bit_d = nxt_idx;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            de_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         de_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         de_q    <= de_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx_state = busy_q;
   assign tx_done  = done_q;
   assign rs485_de = de_q;
   assign rs232_tx = tx_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: five configurations (8N1, 8E1, 8O1, 8E2, 8N1 without lead), BPS_PARAM=10.
// Stimulus pushes expected frames; a per-instance line monitor decodes the wire and checks on tx_done.
module tb_uart_byte_tx;

   localparam int NI = 5;
   localparam int PAR_C [NI] = '{0, 2, 1, 2, 0};
   localparam int STP_C [NI] = '{1, 1, 1, 2, 1};
   localparam int LD_C  [NI] = '{1, 1, 1, 1, 0};

   typedef struct {
      logic [7:0] data;
      logic       par;
      int         acc;
      int         slat;
      int         dlat;
      logic       de_end;
      logic       chk_rise;
      logic       chk_par;
   } exp_t;

   logic          clk = 1'b0;
   logic [NI-1:0] rst;
   logic [NI-1:0] start;
   logic [NI-1:0] state;
   logic [NI-1:0] done;
   logic [NI-1:0] de;
   logic [NI-1:0] tx;
   logic [7:0]    data [NI];

   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t expq [NI][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic p, input int acc, input int slat,
                               input int dlat, input logic de_end, input logic chk_rise,
                               input logic chk_par);
      exp_t e;
      e.data = d; e.par = p; e.acc = acc; e.slat = slat; e.dlat = dlat;
      e.de_end = de_end; e.chk_rise = chk_rise; e.chk_par = chk_par;
      return e;
   endfunction

   // raise tx_start at a negedge and record the expected frame (accept cycle = current cyc)
   task automatic send(input int i, input logic [7:0] d, input logic p, input int slat,
                       input int dlat, input logic chk_par);
      data[i]  = d;
      start[i] = 1'b1;
      expq[i].push_back(mk(d, p, cyc, slat, dlat, 1'b0, 1'b1, chk_par));
   endtask

   for (genvar g = 0; g < NI; g++) begin : gi
      localparam int P = (PAR_C[g] == 1 || PAR_C[g] == 2) ? 1 : 0;

      uart_byte_tx #(
         .CLK_FREQ (1000000),
         .BAUD_RATE(100000),
         .PARITY   (PAR_C[g]),
         .STOP_BITS(STP_C[g]),
         .DE_LEAD  (LD_C[g])
      ) u_dut (
         .clk_in  (clk),
         .rst_in  (rst[g]),
         .tx_data (data[g]),
         .tx_start(start[g]),
         .tx_state(state[g]),
         .tx_done (done[g]),
         .rs485_de(de[g]),
         .rs232_tx(tx[g])
      );

      initial begin : mon
         logic       inf, ptx, pde, shape_ok, rxp;
         logic [7:0] rx;
         int         st, rise, off, k;
         exp_t       e;
         inf = 1'b0; ptx = 1'b1; pde = 1'b0; shape_ok = 1'b1; rxp = 1'b0;
         rx = '0; st = 0; rise = -1; off = 0; k = 0;
         forever begin
            @(negedge clk);
            if (rst[g]) begin
               inf = 1'b0; ptx = 1'b1; pde = 1'b0;
            end else begin
               if (de[g] && !pde) rise = cyc;
               if (!inf && ptx && !tx[g]) begin
                  inf = 1'b1; st = cyc; shape_ok = 1'b1;
               end
               if (inf) begin
                  off = cyc - st;
                  if (off % 10 == 5) begin
                     k = off / 10;
                     if (k == 0) shape_ok = shape_ok & !tx[g];
                     else if (k <= 8) rx = {tx[g], rx[7:1]};
                     else if (k == 9 && P == 1) rxp = tx[g];
                     else shape_ok = shape_ok & tx[g];
                  end
               end
               if (done[g]) begin
                  inf = 1'b0;
                  if (expq[g].size() == 0) begin
                     tests++;
                     fails++;
                     $display("FAIL unexpected_done inst%0d: got tx_done=1, required no frame (cycle %0d)", g, cyc);
                  end else begin
                     e = expq[g].pop_front();
                     chk($sformatf("inst%0d data", g), int'(rx), int'(e.data));
                     if (e.chk_par) chk($sformatf("inst%0d parity", g), int'(rxp), int'(e.par));
                     chk($sformatf("inst%0d start_latency", g), st - e.acc, e.slat);
                     chk($sformatf("inst%0d done_latency", g), cyc - e.acc, e.dlat);
                     chk($sformatf("inst%0d de_at_done", g), int'(de[g]), int'(e.de_end));
                     chk($sformatf("inst%0d start_stop_levels", g), int'(shape_ok && tx[g]), 1);
                     chk($sformatf("inst%0d state_at_done", g), int'(state[g]), 0);
                     if (e.chk_rise) chk($sformatf("inst%0d de_rise_latency", g), rise - e.acc, 1);
                  end
               end
               ptx = tx[g];
               pde = de[g];
            end
         end
      end
   end

   initial begin
      int lows;
      int bad;
      int c;
      rst   = '1;
      start = '0;
      for (int i = 0; i < NI; i++) data[i] = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++)
         chk($sformatf("reset_outputs inst%0d {tx,de,state,done}", i),
             int'({tx[i], de[i], state[i], done[i]}), 4'b1000);
      rst = '0;
      repeat (2) @(negedge clk);

      // 8N1 with lead, 0xA5
      send(0, 8'hA5, 1'b0, 11, 111, 1'b0);
      @(negedge clk); start[0] = 1'b0;
      repeat (130) @(negedge clk);

      // parity variants on 0x03
      send(1, 8'h03, 1'b0, 11, 121, 1'b1);
      @(negedge clk); start[1] = 1'b0;
      repeat (140) @(negedge clk);
      send(2, 8'h03, 1'b1, 11, 121, 1'b1);
      @(negedge clk); start[2] = 1'b0;
      repeat (140) @(negedge clk);
      send(3, 8'h03, 1'b0, 11, 131, 1'b1);
      @(negedge clk); start[3] = 1'b0;
      repeat (150) @(negedge clk);

      // no lead, 0x00: start + 8 zero bits = 90 low clocks
      send(4, 8'h00, 1'b0, 1, 101, 1'b0);
      lows = 0;
      for (int k = 0; k < 120; k++) begin
         @(negedge clk);
         if (k == 0) start[4] = 1'b0;
         if (!tx[4]) lows++;
      end
      chk("inst4 low_cycles", lows, 90);
      repeat (10) @(negedge clk);

      // reset in the middle of DATA for 0x55: abort, no tx_done
      data[0]  = 8'h55;
      start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort busy_before_reset", int'(state[0]), 1);
      @(posedge clk);
      #2 rst[0] = 1'b1;
      #1 chk("abort outputs {tx,de,state}", int'({tx[0], de[0], state[0]}), 3'b100);
      repeat (3) @(negedge clk);
      rst[0] = 1'b0;
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (!tx[0] || de[0] || state[0] || done[0]) bad++;
      end
      chk("abort idle_after_release", bad, 0);

      // busy rejection: 0xFF requested mid-frame of 0x12
      send(0, 8'h12, 1'b0, 11, 111, 1'b0);
      @(negedge clk); start[0] = 1'b0;
      repeat (50) @(negedge clk);
      data[0]  = 8'hFF;
      start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      repeat (200) @(negedge clk);

      // back-to-back with tx_start held high: 0x11 then 0x22
      c        = cyc;
      data[0]  = 8'h11;
      start[0] = 1'b1;
      expq[0].push_back(mk(8'h11, 1'b0, c, 11, 111, 1'b1, 1'b1, 1'b0));
      expq[0].push_back(mk(8'h22, 1'b0, c + 111, 11, 111, 1'b0, 1'b0, 1'b0));
      lows = 0;
      for (int k = 0; k < 221; k++) begin
         @(negedge clk);
         if (k == 0) data[0] = 8'h22;
         if (k == 160) start[0] = 1'b0;
         if (!de[0]) lows++;
      end
      chk("b2b de_low_cycles", lows, 0);
      repeat (150) @(negedge clk);

      for (int i = 0; i < NI; i++)
         chk($sformatf("inst%0d frames_outstanding", i), expq[i].size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
